// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampled UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    WAIT_HIGH,
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_rx_state_e;

  localparam int unsigned OVERSAMPLE       = 16;
  localparam int unsigned SAMPLE_MID       = 8;
  localparam int unsigned DEFAULT_BAUD_DIV = 651;

endpackage

// File: rtl/uart_baud_tick_gen.sv
// Oversample tick generator: free-running 0..DIV-1 counter, one-cycle tick at DIV-1,
// synchronous clear so the sample phase can be re-aligned to a start edge.
module uart_baud_tick_gen
  import uart_pkg::*;
#(
  parameter int unsigned DIV = DEFAULT_BAUD_DIV
) (
  input  logic clk,
  input  logic arst_n,
  input  logic i_clr,
  output logic o_tick
);

  localparam int unsigned CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] r_cnt;
  logic          w_wrap;

  assign w_wrap = (r_cnt == CW'(DIV - 1));
  assign o_tick = w_wrap & ~i_clr;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_cnt <= '0;
    end else if (i_clr || w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_oversampled.sv
// 16x oversampled UART receiver (8N1, or 8E1 when UART_RX_PARITY_EN is defined) with
// 3-sample mid-bit majority vote and false-start rejection.
module uart_rx_oversampled #(
  parameter int unsigned CLK_FREQ   = 100_000_000,
  parameter int unsigned BAUD_RATE  = 9600,
  parameter int unsigned OVERSAMPLE = uart_pkg::OVERSAMPLE,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  i_rx,
  output logic [DATA_WIDTH-1:0] o_data_out,
  output logic                  o_rx_done,
  output logic                  o_frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                  o_parity_err,
`endif
  output logic                  o_busy
);

  import uart_pkg::*;

  localparam int unsigned DIV = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int unsigned BW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  logic                  r_rx_meta, r_rx_s;
  uart_rx_state_e        r_state, w_state_d;
  logic [3:0]            r_s_cnt, w_s_cnt_d;
  logic [BW-1:0]         r_bit_cnt, w_bit_cnt_d;
  logic [1:0]            r_samp, w_samp_d;
  logic [DATA_WIDTH-1:0] r_shift, w_shift_d;
  logic [DATA_WIDTH-1:0] r_data_out, w_data_d;
  logic                  r_rx_done, w_done_d;
  logic                  r_frame_err, w_ferr_d;
  logic                  r_busy, w_busy_d;
  logic                  w_clr, w_tick, w_vote, w_mid, w_end;
`ifdef UART_RX_PARITY_EN
  logic                  r_par_bad, w_par_bad_d;
  logic                  r_parity_err, w_perr_d;
`endif

  uart_baud_tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .clk    (clk),
    .arst_n (arst_n),
    .i_clr  (w_clr),
    .o_tick (w_tick)
  );

  // Third sample is taken live on the resolving tick.
  assign w_vote = (r_samp[0] & r_samp[1]) | (r_samp[0] & r_rx_s) | (r_samp[1] & r_rx_s);
  assign w_mid  = w_tick && (r_s_cnt == 4'(SAMPLE_MID + 1));
  assign w_end  = w_tick && (r_s_cnt == 4'(OVERSAMPLE - 1));

  always_comb begin
    w_state_d   = r_state;
    w_s_cnt_d   = r_s_cnt;
    w_bit_cnt_d = r_bit_cnt;
    w_samp_d    = r_samp;
    w_shift_d   = r_shift;
    w_data_d    = r_data_out;
    w_done_d    = 1'b0;
    w_ferr_d    = 1'b0;
    w_clr       = 1'b0;
`ifdef UART_RX_PARITY_EN
    w_par_bad_d = r_par_bad;
    w_perr_d    = 1'b0;
`endif

    if (w_tick) begin
      w_s_cnt_d = r_s_cnt + 4'd1;
      if (r_s_cnt == 4'(SAMPLE_MID - 1)) w_samp_d[0] = r_rx_s;
      if (r_s_cnt == 4'(SAMPLE_MID))     w_samp_d[1] = r_rx_s;
    end

    unique case (r_state)
      WAIT_HIGH: begin
        if (w_tick && r_rx_s) w_state_d = IDLE;
      end
      IDLE: begin
        if (!r_rx_s) begin
          w_clr     = 1'b1;
          w_s_cnt_d = 4'd0;
          w_state_d = START;
        end
      end
      START: begin
        if (w_mid && w_vote) begin
          w_state_d = IDLE;
        end else if (w_end) begin
          w_bit_cnt_d = '0;
          w_state_d   = DATA;
        end
      end
      DATA: begin
        if (w_mid) w_shift_d = {w_vote, r_shift[DATA_WIDTH-1:1]};
        if (w_end) begin
          if (r_bit_cnt == BW'(DATA_WIDTH - 1)) begin
`ifdef UART_RX_PARITY_EN
            w_state_d = PARITY;
`else
            w_state_d = STOP;
`endif
          end else begin
            w_bit_cnt_d = r_bit_cnt + 1'b1;
          end
        end
      end
      PARITY: begin
`ifdef UART_RX_PARITY_EN
        if (w_mid) w_par_bad_d = (w_vote != ^r_shift);
`endif
        if (w_end) w_state_d = STOP;
      end
      STOP: begin
        // Leave at mid-stop so a back-to-back start edge is not missed.
        if (w_mid) begin
          if (w_vote) begin
            w_data_d  = r_shift;
            w_done_d  = 1'b1;
`ifdef UART_RX_PARITY_EN
            w_perr_d  = r_par_bad;
`endif
            w_state_d = IDLE;
          end else begin
            w_ferr_d  = 1'b1;
            w_state_d = WAIT_HIGH;
          end
        end
      end
      default: w_state_d = WAIT_HIGH;
    endcase

    w_busy_d = !((w_state_d == IDLE) || (w_state_d == WAIT_HIGH));
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_rx_meta    <= 1'b1;
      r_rx_s       <= 1'b1;
      r_state      <= WAIT_HIGH;
      r_s_cnt      <= '0;
      r_bit_cnt    <= '0;
      r_samp       <= '0;
      r_shift      <= '0;
      r_data_out   <= '0;
      r_rx_done    <= 1'b0;
      r_frame_err  <= 1'b0;
      r_busy       <= 1'b0;
`ifdef UART_RX_PARITY_EN
      r_par_bad    <= 1'b0;
      r_parity_err <= 1'b0;
`endif
    end else begin
      r_rx_meta    <= i_rx;
      r_rx_s       <= r_rx_meta;
      r_state      <= w_state_d;
      r_s_cnt      <= w_s_cnt_d;
      r_bit_cnt    <= w_bit_cnt_d;
      r_samp       <= w_samp_d;
      r_shift      <= w_shift_d;
      r_data_out   <= w_data_d;
      r_rx_done    <= w_done_d;
      r_frame_err  <= w_ferr_d;
      r_busy       <= w_busy_d;
`ifdef UART_RX_PARITY_EN
      r_par_bad    <= w_par_bad_d;
      r_parity_err <= w_perr_d;
`endif
    end
  end

  assign o_data_out  = r_data_out;
  assign o_rx_done   = r_rx_done;
  assign o_frame_err = r_frame_err;
  assign o_busy      = r_busy;
`ifdef UART_RX_PARITY_EN
  assign o_parity_err = r_parity_err;
`endif

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Self-checking bench for uart_rx_oversampled; DIV is shrunk to 4 to keep frames short.
module tb_uart_rx_oversampled;

  localparam int unsigned BAUD = 9600;
  localparam int unsigned CLKF = 614_400;
  localparam int DIV  = 4;
  localparam int BIT  = 16 * DIV;
  localparam int NONE = 1 << 30;
`ifdef UART_RX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int LAT = ((NB - 1) * 16 + 10) * DIV + 3;

  logic       clk = 1'b0;
  logic       arst_n;
  logic       rx;
  logic [7:0] data_out;
  logic       done, ferr, perr, busy;

  uart_rx_oversampled #(
    .CLK_FREQ   (CLKF),
    .BAUD_RATE  (BAUD),
    .OVERSAMPLE (16),
    .DATA_WIDTH (8)
  ) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .i_rx         (rx),
    .o_data_out   (data_out),
    .o_rx_done    (done),
    .o_frame_err  (ferr),
`ifdef UART_RX_PARITY_EN
    .o_parity_err (perr),
`endif
    .o_busy       (busy)
  );

`ifndef UART_RX_PARITY_EN
  assign perr = 1'b0;
`endif

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] done_q[$];
  int         done_t[$];
  int         n_ferr, n_perr, perr_t, t_start;
  int         n_checks = 0;
  int         n_err    = 0;

  always @(negedge clk) begin
    if (arst_n) begin
      if (done) begin
        done_q.push_back(data_out);
        done_t.push_back(cyc);
      end
      if (ferr) n_ferr++;
      if (perr) begin
        n_perr++;
        perr_t = cyc;
      end
    end
  end

  typedef struct {
    logic [7:0] d;
    bit         stop;
    bit         pbit;
    logic [7:0] exp_data;
    int         exp_done;
    int         exp_ferr;
    int         exp_perr;
  } vec_t;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic clear_mon();
    done_q.delete();
    done_t.delete();
    n_ferr = 0;
    n_perr = 0;
    perr_t = -1;
  endtask

  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame cycle by cycle; optional one-tick inverted spike and early cut-off.
  task automatic send_frame(input logic [7:0] d, input bit stop, input bit pbit, input int blen,
                            input int sp, input int cut);
    logic [12:0] bits;
    int          nb;
    logic        v;
    bits = '0;
    for (int i = 0; i < 8; i++) bits[1+i] = d[i];
    nb = 9;
`ifdef UART_RX_PARITY_EN
    bits[nb] = pbit;
    nb++;
`else
    if (pbit) bits[12] = 1'b0;
`endif
    bits[nb] = stop;
    nb++;
    if (!stop) nb++;
    t_start = cyc;
    for (int j = 0; j < nb * blen; j++) begin
      if (j >= cut) break;
      v = bits[j/blen];
      if (j >= sp && j < sp + DIV) v = ~v;
      rx = v;
      @(posedge clk);
      #1;
    end
    rx = 1'b1;
  endtask

  task automatic run_vec(input string name, input logic [7:0] d, input bit stop, input bit pbit,
                         input int blen, input logic [7:0] exp_data, input int exp_done,
                         input int exp_ferr, input int exp_perr);
    clear_mon();
    send_frame(d, stop, pbit, blen, NONE, NONE);
    idle(2 * BIT);
    check({name, " rx_done count"}, done_q.size(), exp_done);
    check({name, " frame_err count"}, n_ferr, exp_ferr);
    check({name, " data_out"}, data_out, exp_data);
    check({name, " busy idle"}, busy, 0);
`ifdef UART_RX_PARITY_EN
    check({name, " parity_err count"}, n_perr, exp_perr);
    if (exp_perr != 0 && done_t.size() > 0) check({name, " perr with done"}, perr_t, done_t[0]);
`else
    if (exp_perr > 1) check({name, " parity_err bogus"}, n_perr, 0);
`endif
  endtask

  vec_t       vt[5];
  logic [7:0] model_last;

  initial begin
    vt[0] = '{d: 8'h3C, stop: 1'b0, pbit: 1'b0, exp_data: 8'hA5, exp_done: 0, exp_ferr: 1,
              exp_perr: 0};
    vt[1] = '{d: 8'h81, stop: 1'b1, pbit: 1'b0, exp_data: 8'h81, exp_done: 1, exp_ferr: 0,
              exp_perr: 0};
    vt[2] = '{d: 8'h07, stop: 1'b1, pbit: 1'b0, exp_data: 8'h07, exp_done: 1, exp_ferr: 0,
              exp_perr: 1};
    vt[3] = '{d: 8'h07, stop: 1'b1, pbit: 1'b1, exp_data: 8'h07, exp_done: 1, exp_ferr: 0,
              exp_perr: 0};
    vt[4] = '{d: 8'hC3, stop: 1'b1, pbit: 1'b0, exp_data: 8'hC3, exp_done: 1, exp_ferr: 0,
              exp_perr: 0};

    // Reset values, with the line held low across reset release.
    rx     = 1'b0;
    arst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("reset data_out", data_out, 0);
    check("reset rx_done", done, 0);
    check("reset frame_err", ferr, 0);
    check("reset busy", busy, 0);
    arst_n = 1'b1;
    clear_mon();
    repeat (3 * BIT) @(posedge clk);
    #1;
    check("low at release busy", busy, 0);
    check("low at release events", done_q.size() + n_ferr, 0);
    idle(2 * BIT);

    // First valid frame and its latency.
    clear_mon();
    send_frame(8'hA5, 1'b1, 1'b0, BIT, NONE, NONE);
    idle(2 * BIT);
    check("A5 rx_done count", done_q.size(), 1);
    check("A5 frame_err", n_ferr, 0);
    check("A5 data_out", data_out, 8'hA5);
    if (done_t.size() > 0) check("A5 latency", done_t[0] - t_start, LAT);

    foreach (vt[i]) begin
      run_vec($sformatf("vec%0d", i), vt[i].d, vt[i].stop, vt[i].pbit, BIT, vt[i].exp_data,
              vt[i].exp_done, vt[i].exp_ferr, vt[i].exp_perr);
    end

    // Glitch: four ticks low is a false start.
    clear_mon();
    rx = 1'b0;
    repeat (4 * DIV) @(posedge clk);
    #1;
    check("glitch busy high", busy, 1);
    idle(2 * BIT);
    check("glitch events", done_q.size() + n_ferr, 0);
    check("glitch busy low", busy, 0);
    run_vec("after glitch", 8'h5A, 1'b1, 1'b0, BIT, 8'h5A, 1, 0, 0);

    // Back-to-back frames, one stop bit between them.
    clear_mon();
    send_frame(8'h00, 1'b1, 1'b0, BIT, NONE, NONE);
    send_frame(8'hFF, 1'b1, 1'b0, BIT, NONE, NONE);
    idle(2 * BIT);
    check("b2b rx_done count", done_q.size(), 2);
    if (done_q.size() >= 2) begin
      check("b2b first", done_q[0], 8'h00);
      check("b2b second", done_q[1], 8'hFF);
      check("b2b spacing", done_t[1] - done_t[0], NB * BIT);
    end

    // Inverted one-tick spike on sample 8 of data bit 3.
    clear_mon();
    send_frame(8'h0F, 1'b1, 1'b0, BIT, DIV * (16 * 4 + 9) - DIV / 2, NONE);
    idle(2 * BIT);
    check("spike rx_done count", done_q.size(), 1);
    check("spike data_out", data_out, 8'h0F);

    // Reset during data bit 4 with the line low.
    clear_mon();
    send_frame(8'h33, 1'b1, 1'b0, BIT, NONE, 5 * BIT + BIT / 2);
    rx     = 1'b0;
    arst_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("midreset busy", busy, 0);
    arst_n = 1'b1;
    repeat (2 * BIT) @(posedge clk);
    #1;
    check("midreset busy after", busy, 0);
    idle(2 * BIT);
    check("midreset events", done_q.size() + n_ferr, 0);
    check("midreset data_out", data_out, 0);
    run_vec("after reset", 8'h33, 1'b1, 1'b0, BIT, 8'h33, 1, 0, 0);

    // Random frames with about 1.5% bit-length error, against a frame-level model.
    model_last = 8'h33;
    for (int n = 0; n < 24; n++) begin
      logic [7:0] d;
      bit         stop, pbit;
      int         blen, e_perr;
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 4) != 0);
      pbit = 1'($urandom_range(0, 1));
      blen = BIT - 1 + int'($urandom_range(0, 2));
`ifdef UART_RX_PARITY_EN
      e_perr = (stop && (pbit != ^d)) ? 1 : 0;
`else
      e_perr = 0;
`endif
      if (stop) model_last = d;
      run_vec($sformatf("rand%0d", n), d, stop, pbit, blen, model_last, stop ? 1 : 0,
              stop ? 0 : 1, e_perr);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/uart_rx_oversampled.md
# uart_rx_oversampled

16x-oversampling UART receiver: it recovers 8N1 frames from the serial line driven by the UART transmitter. It sits on the receive side of the UART path and is instantiated in place of, or alongside, the loopback receiver in the top level. Each frame yields a parallel byte plus a one-cycle `rx_done` strobe, with a framing-error strobe on a bad stop bit. Noise rejection uses a mid-bit 3-sample majority vote and false-start filtering.

## Interface
- `CLK_FREQ`, default 100_000_000: clock frequency in Hz.
- `BAUD_RATE`, default 9600: line baud rate.
- `OVERSAMPLE`, default 16: ticks per bit. Fixed at 16; other values are unsupported.
- `DATA_WIDTH`, default 8: data bits per frame.
- `clk`  input  1: clock.
- `arst_n`  input  1: reset, asynchronous, active-low.
- `rx`  input  1: asynchronous serial line. Idle high.
- `data_out`  output  DATA_WIDTH: last good byte. Held until the next good frame.
- `rx_done`  output  1: one-cycle pulse when `data_out` is updated.
- `frame_err`  output  1: one-cycle pulse when the stop bit samples low.
- `parity_err`  output  1: one-cycle pulse on parity mismatch. Present only with `UART_RX_PARITY_EN`.
- `busy`  output  1: high in any state other than IDLE and WAIT_HIGH.

## Operation
- `rx` passes through a 2-flop synchronizer that resets to 1, giving `rx_s`.
- Tick generator:
  - DIV = CLK_FREQ/(BAUD_RATE*16), integer division. Default is 651.
  - The counter runs 0..DIV-1 and pulses `tick` for one cycle when count == DIV-1.
  - The counter clears to 0 on start-edge detection, so sample phase aligns to the edge.
- Sample counter `s_cnt` is 4 bits and counts ticks within a bit. It wraps 15 -> 0, and each wrap advances the bit.
- Majority vote: `rx_s` is captured at s_cnt 7, 8 and 9. The voted bit is 2-of-3 and is resolved on the tick at s_cnt 9.
- States:
  - WAIT_HIGH (reset state): go to IDLE on the first tick with `rx_s`=1.
  - IDLE: on `rx_s`=0, clear the tick and s_cnt counters and go to START.
  - START: if the vote is 1 (false start), go to IDLE with no output. If the vote is 0, go to DATA on the s_cnt 15 wrap.
  - DATA: shift the voted bit in LSB first into a DATA_WIDTH shift register. After bit DATA_WIDTH-1, go to PARITY if the macro is defined, otherwise STOP.
  - PARITY: compare the voted bit against even parity of the shift register and latch mismatch in `par_bad`. Go to STOP.
  - STOP: act on the vote at s_cnt 9, then leave the state immediately (mid-stop) so a back-to-back start edge is caught.
    - Vote 1: `data_out` <= shift register, pulse `rx_done`, and pulse `parity_err` if `par_bad`. Go to IDLE.
    - Vote 0: pulse `frame_err`, leave `data_out` unchanged, no `rx_done`. Go to WAIT_HIGH, which absorbs a break.
- Precedence: a framing error suppresses `parity_err` and `rx_done`.
- `busy` and all outputs are registered.

## Timing
- Reset values:
  - `data_out`=0, `rx_done`=0, `frame_err`=0, `parity_err`=0, `busy`=0.
  - state=WAIT_HIGH, synchronizer=1, counters=0.
- Reset mid-frame aborts silently. Because of WAIT_HIGH, a low line at reset release is never taken as a start.
- Latency from the `rx` falling edge to `rx_done`:
  - 2 synchronizer cycles, plus (9*16+10)*DIV cycles, plus 1 register cycle.
  - With defaults this is about 100,257 cycles.
  - With the macro, add 16*DIV = 10,416 cycles.
- `rx_done`, `frame_err` and `parity_err` are exactly one `clk` wide and never repeat for one frame.
- Baud tolerance: ±3% total clock mismatch must decode correctly.

## Configuration
- `UART_RX_PARITY_EN` defined:
  - The PARITY state and the `parity_err` port exist.
  - Frames are 8E1 with even parity.
- `UART_RX_PARITY_EN` undefined:
  - No PARITY state and no `parity_err` port.
  - Frames are 8N1.

## Structure
- `uart_pkg` holds:
  - `uart_rx_state_e`: WAIT_HIGH, IDLE, START, DATA, PARITY, STOP.
  - `OVERSAMPLE`=16, `SAMPLE_MID`=8, `DEFAULT_BAUD_DIV`=651.
- Sub-module `uart_baud_tick_gen` contains the tick counter with synchronous clear. The rest of the receiver is in the top module.

## Test plan
- Valid frame 0xA5 at 9600 baud, LSB first, stop=1 -> `data_out`=0xA5 and a single `rx_done` about 100,257 cycles after the start edge. `frame_err`=0.
- Glitch: `rx` low for 4 ticks (2,604 cycles), then high -> no `rx_done` and no `frame_err`. `busy` falls back to 0. A following 0x5A frame decodes.
- Framing error: 0x3C with stop=0, line held low 2 bit-times, then high -> `frame_err` pulses once, `data_out` stays 0xA5, no `rx_done`. A next frame 0x81 gives `data_out`=0x81.
- Back-to-back 0x00 then 0xFF with exactly one stop bit between them -> two `rx_done` pulses 10 bit-times (104,160 cycles) apart, with `data_out` 0x00 then 0xFF.
- Noise and reset: a single-tick inverted spike at s_cnt 8 of bit 3 in 0x0F -> still 0x0F. Assert `arst_n` during bit 4 of 0x33 with `rx` low -> no output. After `rx` returns high, frame 0x33 decodes.
- With `UART_RX_PARITY_EN`: 0x07 with parity bit 0 -> `rx_done` plus `parity_err` in the same cycle, `data_out`=0x07. The same byte with parity bit 1 -> `rx_done` only.
